// File: rtl/dog_sprite_anim_if.sv
// Pixel/handshake bundle for the animated dog sprite.
// frame_clk and start are plain level/pulse inputs with no ready back-pressure:
// start is a 1-Clk request the block takes only when idle (busy=0),
// and done is a 1-Clk completion pulse. The dbg_* signals expose the internal
// FSM state and motion registers so checkers can bind to them directly.
interface dog_sprite_anim_if;
  logic       frame_clk;
  logic       start;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       is_dog;
  logic [7:0] spr_col;
  logic [7:0] spr_row;
  logic [2:0] cel;
  logic       busy;
  logic       done;
  logic [2:0] dbg_state;
  logic [9:0] dbg_x;
  logic [9:0] dbg_y;
  logic [3:0] dbg_vel;

  modport slave (
    input  frame_clk, start, DrawX, DrawY,
    output is_dog, spr_col, spr_row, cel, busy, done,
    output dbg_state, dbg_x, dbg_y, dbg_vel
  );

  modport master (
    output frame_clk, start, DrawX, DrawY,
    input  is_dog, spr_col, spr_row, cel, busy, done,
    input  dbg_state, dbg_x, dbg_y, dbg_vel
  );
endinterface

// File: rtl/dog_sprite_anim.sv
// Animated Duck Hunt intro dog: walk -> sniff -> jump -> fall behind grass.
// Motion advances only on frame ticks; pixel coverage is combinational.
module dog_sprite_anim #(
  parameter int SPR_W         = 56,
  parameter int SPR_H         = 48,
  parameter int START_X       = 0,
  parameter int STOP_X        = 280,
  parameter int GROUND_Y      = 360,
  parameter int GRASS_Y       = 400,
  parameter int WALK_STEP     = 2,
  parameter int JUMP_V        = 8,
  parameter int SNIFF_TICKS   = 90,
  parameter int TICKS_PER_CEL = 8,
  parameter int NUM_WALK_CELS = 4
) (
  input logic              Clk,
  input logic              Reset,
  dog_sprite_anim_if.slave bus
);

  localparam logic [10:0] SPR_W_L     = 11'(SPR_W);
  localparam logic [10:0] SPR_H_L     = 11'(SPR_H);
  localparam logic [9:0]  START_X_L   = 10'(START_X);
  localparam logic [10:0] STOP_X_L    = 11'(STOP_X);
  localparam logic [9:0]  GROUND_Y_L  = 10'(GROUND_Y);
  localparam logic [10:0] GRASS_Y_L   = 11'(GRASS_Y);
  localparam logic [10:0] WALK_STEP_L = 11'(WALK_STEP);
  localparam logic [3:0]  JUMP_V_L    = 4'(JUMP_V);
  localparam logic [15:0] SNIFF_LAST  = 16'(SNIFF_TICKS - 1);
  localparam logic [15:0] CEL_LAST    = 16'(TICKS_PER_CEL - 1);
  localparam logic [2:0]  WALK_LAST   = 3'(NUM_WALK_CELS - 1);
  localparam logic [2:0]  CEL_SNIFF   = 3'(NUM_WALK_CELS);
  localparam logic [2:0]  CEL_JUMP    = 3'(NUM_WALK_CELS + 1);
  localparam logic [2:0]  CEL_FALL    = 3'(NUM_WALK_CELS + 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WALK  = 3'd1,
    S_SNIFF = 3'd2,
    S_JUMP  = 3'd3,
    S_FALL  = 3'd4
  } state_t;

  state_t      state_q;
  logic [9:0]  x_q;
  logic [9:0]  y_q;
  logic [3:0]  vel_q;
  logic [15:0] tick_cnt_q;
  logic [2:0]  cel_q;
  logic        busy_q;
  logic        done_q;
  logic        frame_clk_q;
  logic        tick;

  logic [10:0] walk_x_d;
  logic [10:0] jump_y_d;
  logic [10:0] fall_y_d;
  logic [3:0]  fall_vel_d;
  logic [9:0]  fall_y_sat_d;

  // Rising edge of the frame strobe, visible in the Clk after the edge.
  assign tick = bus.frame_clk & ~frame_clk_q;

  // Candidate positions with an extra bit to catch overflow/underflow.
  always_comb begin
    walk_x_d     = {1'b0, x_q} + WALK_STEP_L;
    fall_vel_d   = (vel_q == 4'hf) ? vel_q : vel_q + 4'd1;
    jump_y_d     = ({1'b0, y_q} >= {7'd0, vel_q}) ? ({1'b0, y_q} - {7'd0, vel_q}) : 11'd0;
    fall_y_d     = {1'b0, y_q} + {7'd0, fall_vel_d};
    fall_y_sat_d = fall_y_d[10] ? 10'h3ff : fall_y_d[9:0];
  end

  // Intro sequencer: state, motion registers and status outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      x_q         <= START_X_L;
      y_q         <= GROUND_Y_L;
      vel_q       <= 4'd0;
      tick_cnt_q  <= 16'd0;
      cel_q       <= 3'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_clk_q <= 1'b0;
    end else begin
      frame_clk_q <= bus.frame_clk;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A tick coinciding with start is deliberately not used as a step.
          if (bus.start) begin
            state_q    <= S_WALK;
            busy_q     <= 1'b1;
            tick_cnt_q <= 16'd0;
            cel_q      <= 3'd0;
          end
        end
        S_WALK: begin
          if (tick) begin
            if (walk_x_d >= STOP_X_L) begin
              x_q        <= STOP_X_L[9:0];
              state_q    <= S_SNIFF;
              tick_cnt_q <= 16'd0;
              cel_q      <= CEL_SNIFF;
            end else begin
              x_q <= walk_x_d[9:0];
              if (tick_cnt_q == CEL_LAST) begin
                tick_cnt_q <= 16'd0;
                cel_q      <= (cel_q == WALK_LAST) ? 3'd0 : cel_q + 3'd1;
              end else begin
                tick_cnt_q <= tick_cnt_q + 16'd1;
              end
            end
          end
        end
        S_SNIFF: begin
          if (tick) begin
            if (tick_cnt_q == SNIFF_LAST) begin
              state_q    <= S_JUMP;
              vel_q      <= JUMP_V_L;
              cel_q      <= CEL_JUMP;
              tick_cnt_q <= 16'd0;
            end else begin
              tick_cnt_q <= tick_cnt_q + 16'd1;
            end
          end
        end
        S_JUMP: begin
          if (tick) begin
            y_q <= jump_y_d[9:0];
            // vel<=1 also covers a zero launch speed without wrapping.
            if (vel_q <= 4'd1) begin
              vel_q   <= 4'd0;
              state_q <= S_FALL;
              cel_q   <= CEL_FALL;
            end else begin
              vel_q <= vel_q - 4'd1;
            end
          end
        end
        S_FALL: begin
          if (tick) begin
            if (fall_y_d >= GRASS_Y_L) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              x_q     <= START_X_L;
              y_q     <= GROUND_Y_L;
              vel_q   <= 4'd0;
              cel_q   <= 3'd0;
            end else begin
              vel_q <= fall_vel_d;
              y_q   <= fall_y_sat_d;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic [10:0] dx;
  logic [10:0] dy;
  logic        in_x;
  logic        in_y;
  logic        hidden;
  logic        is_dog_c;

  // Zero-latency pixel coverage; the box is half-open and never wraps.
  always_comb begin
    dx       = {1'b0, bus.DrawX};
    dy       = {1'b0, bus.DrawY};
    in_x     = (dx >= {1'b0, x_q}) && (dx < ({1'b0, x_q} + SPR_W_L));
    in_y     = (dy >= {1'b0, y_q}) && (dy < ({1'b0, y_q} + SPR_H_L));
    hidden   = (state_q == S_FALL) && (dy >= GRASS_Y_L);
    is_dog_c = (state_q != S_IDLE) && in_x && in_y && !hidden;
  end

  // Offsets are below 256 inside the box, so 8-bit differences are exact.
  assign bus.is_dog    = is_dog_c;
  assign bus.spr_col   = is_dog_c ? (bus.DrawX[7:0] - x_q[7:0]) : 8'd0;
  assign bus.spr_row   = is_dog_c ? (bus.DrawY[7:0] - y_q[7:0]) : 8'd0;
  assign bus.cel       = cel_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;
  assign bus.dbg_x     = x_q;
  assign bus.dbg_y     = y_q;
  assign bus.dbg_vel   = vel_q;

endmodule

// File: tb/tb_dog_sprite_anim.sv
// Self-checking bench for dog_sprite_anim with default parameters.
module tb_dog_sprite_anim;

  // Phase codes as exposed on dbg_state.
  localparam int P_IDLE  = 0;
  localparam int P_WALK  = 1;
  localparam int P_SNIFF = 2;
  localparam int P_JUMP  = 3;
  localparam int P_FALL  = 4;

  logic Clk;
  logic Reset;
  dog_sprite_anim_if bus ();

  dog_sprite_anim dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // Clock and watchdog
  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  int done_seen = 0;

  always @(negedge Clk) if (bus.done === 1'b1) done_seen++;

  // Reference model: positions and phase derived from the behavioural rules.
  int m_state, m_x, m_y, m_vel, m_walk_ticks, m_sniff, m_busy, m_done_now;
  int m_done_total;

  function automatic int exp_cel();
    case (m_state)
      P_WALK:  return (m_walk_ticks / 8) % 4;
      P_SNIFF: return 4;
      P_JUMP:  return 5;
      P_FALL:  return 6;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_state = P_IDLE; m_x = 0; m_y = 360; m_vel = 0;
    m_walk_ticks = 0; m_sniff = 0; m_busy = 0; m_done_now = 0;
  endtask

  task automatic model_start();
    if (m_state == P_IDLE) begin
      m_state = P_WALK; m_busy = 1; m_walk_ticks = 0;
    end
  endtask

  task automatic model_tick();
    m_done_now = 0;
    case (m_state)
      P_WALK: begin
        m_walk_ticks++;
        if (m_x + 2 >= 280) begin m_x = 280; m_state = P_SNIFF; m_sniff = 0; end
        else m_x += 2;
      end
      P_SNIFF: begin
        m_sniff++;
        if (m_sniff == 90) begin m_state = P_JUMP; m_vel = 8; end
      end
      P_JUMP: begin
        m_y = (m_y >= m_vel) ? m_y - m_vel : 0;
        m_vel--;
        if (m_vel <= 0) begin m_vel = 0; m_state = P_FALL; end
      end
      P_FALL: begin
        m_vel = (m_vel < 15) ? m_vel + 1 : 15;
        if (m_y + m_vel >= 400) begin
          m_state = P_IDLE; m_done_now = 1; m_done_total++; m_busy = 0;
          m_x = 0; m_y = 360; m_vel = 0;
        end else m_y += m_vel;
      end
      default: ;
    endcase
  endtask

  // Scoreboard compare: expected value is queued, then popped and checked.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    logic [31:0] e;
    exp_q.push_back(exp_v);
    e = exp_q.pop_front();
    n_checks++;
    assert (obs === e) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, e);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic probe(input string tag, input int px, input int py);
    int ex_is, ex_col, ex_row;
    bus.DrawX = 10'(px);
    bus.DrawY = 10'(py);
    #1;
    ex_is = (m_state != P_IDLE) && px >= m_x && px < m_x + 56 && py >= m_y && py < m_y + 48
            && !(m_state == P_FALL && py >= 400);
    check({tag, "_is_dog"}, 32'(bus.is_dog), ex_is);
    check({tag, "_col"}, 32'(bus.spr_col), ex_is ? px - m_x : 0);
    check({tag, "_row"}, 32'(bus.spr_row), ex_is ? py - m_y : 0);
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_state"}, 32'(bus.dbg_state), m_state);
    check({tag, "_x"}, 32'(bus.dbg_x), m_x);
    check({tag, "_y"}, 32'(bus.dbg_y), m_y);
    check({tag, "_vel"}, 32'(bus.dbg_vel), m_vel);
    check({tag, "_cel"}, 32'(bus.cel), exp_cel());
    check({tag, "_busy"}, 32'(bus.busy), m_busy);
  endtask

  task automatic random_probe();
    int px, py;
    px = m_x + int'($urandom_range(0, 63)) - 4;
    py = m_y + int'($urandom_range(0, 55)) - 4;
    if (px < 0) px = 0;
    if (py < 0) py = 0;
    if (px > 1023) px = 1023;
    if (py > 1023) py = 1023;
    probe("rand", px, py);
  endtask

  // One frame: rising edge, held high for hi Clks, low for lo Clks.
  task automatic frame(input int hi, input int lo);
    bus.frame_clk = 1'b1;
    step();
    model_tick();
    check_regs("tick");
    check("done_tick", 32'(bus.done), m_done_now);
    random_probe();
    for (int i = 1; i < hi; i++) begin
      step();
      if (i == 1) check("done_after", 32'(bus.done), 0);
    end
    bus.frame_clk = 1'b0;
    for (int i = 0; i < lo; i++) begin
      // Occasional start while busy must be ignored.
      if (m_state != P_IDLE && $urandom_range(0, 3) == 0) begin
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        model_start();
      end else begin
        step();
      end
    end
  endtask

  task automatic run_sequence(input int hold_at);
    int guard;
    bit pix_sniff, pix_fall;
    guard = 0; pix_sniff = 0; pix_fall = 0;
    while (m_state != P_IDLE && guard < 600) begin
      if (m_state == P_WALK && m_walk_ticks == hold_at) begin
        frame(1000, 2);
        check("hold_one_tick_x", 32'(bus.dbg_x), m_x);
      end else begin
        frame(int'($urandom_range(2, 6)), int'($urandom_range(1, 6)));
      end
      guard++;
      if (m_state == P_SNIFF && !pix_sniff) begin
        pix_sniff = 1;
        check("walk_ticks_to_sniff", m_walk_ticks, 140);
        probe("sniff_origin", 280, 360);
        probe("sniff_right_edge", 336, 360);
        probe("sniff_last_row", 280, 407);
        check("sniff_row47", 32'(bus.spr_row), 47);
      end
      if (m_state == P_FALL && m_vel == 0) begin
        check("jump_apex_y", 32'(bus.dbg_y), 324);
      end
      if (m_state == P_FALL && m_y >= 353 && !pix_fall) begin
        pix_fall = 1;
        probe("fall_grass_row", m_x, 400);
        check("fall_grass_hidden", 32'(bus.is_dog), 0);
        probe("fall_above_grass", m_x, 399);
        check("fall_above_visible", 32'(bus.is_dog), 1);
      end
    end
    check("sequence_bounded", guard < 600, 1);
    check("sequence_probes_hit", pix_sniff && pix_fall, 1);
  endtask

  // Directed test sequence
  initial begin
    m_done_total = 0;
    bus.frame_clk = 1'b0;
    bus.start = 1'b0;
    bus.DrawX = 10'd0;
    bus.DrawY = 10'd360;
    Reset = 1'b1;
    model_reset();
    step();
    step();
    Reset = 1'b0;
    step();
    check_regs("reset");
    check("reset_done", 32'(bus.done), 0);
    probe("reset_pix", 0, 360);

    // Start, walk to x=100, then reset mid-walk.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    model_start();
    check_regs("start");
    while (m_x < 100) frame(int'($urandom_range(2, 4)), int'($urandom_range(1, 4)));
    check("pre_reset_x", 32'(bus.dbg_x), 100);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    model_reset();
    check_regs("midwalk_reset");
    probe("midwalk_reset_pix", 100, 360);

    // Start coinciding with a frame edge: no step on that edge.
    bus.start = 1'b1;
    bus.frame_clk = 1'b1;
    step();
    bus.start = 1'b0;
    model_start();
    check_regs("start_on_tick");
    step();
    bus.frame_clk = 1'b0;
    step();
    step();
    check("start_on_tick_x", 32'(bus.dbg_x), 0);

    run_sequence(50);
    check("seq1_idle", 32'(bus.dbg_state), P_IDLE);

    // Second full run with different random timing.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    model_start();
    check_regs("start2");
    run_sequence(-1);
    check_regs("end2");

    step();
    step();
    check("done_pulse_count", done_seen, m_done_total);
    check("done_total_two", m_done_total, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
